fpu_sub_round: RTL and testbench

Rounding and packing stage directly downstream of the double-precision subtract datapath. It consumes the normalized 56-bit difference, the result exponent, the sign and the shift sticky bit. It applies the IEEE-754 rounding mode and emits a packed 64-bit double with inexact, overflow and underflow flags. Three-stage pipeline with valid/ready backpressure; feeds the FPU exception/result mux.

---
 rtl/fpu_sub_round_if.sv | 26 ++
 rtl/fpu_sub_round.sv | 72 +++++++
 tb/tb_fpu_sub_round.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fpu_sub_round_if.sv
// fpu_sub_round_if: handshake and data bundle between the subtract datapath,
// the round/pack stage and the result mux.
interface fpu_sub_round_if;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic        sign_i;
   logic [55:0] diff_i;
   logic [10:0] exponent_i;
   logic        sticky_i;
   logic [1:0]  round_mode;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result_o;
   logic        inexact_o;
   logic        overflow_o;
   logic        underflow_o;
   modport master (
      output flush, in_valid, sign_i, diff_i, exponent_i, sticky_i, round_mode, out_ready,
      input  in_ready, out_valid, result_o, inexact_o, overflow_o, underflow_o
   );
   modport slave (
      input  flush, in_valid, sign_i, diff_i, exponent_i, sticky_i, round_mode, out_ready,
      output in_ready, out_valid, result_o, inexact_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/fpu_sub_round.sv
// fpu_sub_round: IEEE-754 double rounding and packing after the subtract datapath,
// three register stages (capture, round, output) with valid/ready backpressure.
module fpu_sub_round (
   input logic            clk,
   input logic            rst_n,
   fpu_sub_round_if.slave bus
);
   typedef enum logic [1:0] {RNE, RTZ, RUP, RDN} mode_e;
   logic [2:0]  vld;
   logic        stall;
   logic        s1_sign;
   logic [52:0] s1_mant;
   logic        s1_g, s1_r, s1_s;
   logic [10:0] s1_exp;
   mode_e       s1_mode;
   logic        inx, up, ovf, to_inf, zero;
   logic [53:0] mant_r;
   logic [11:0] exp_r;
   logic [51:0] frac_r;
   logic [63:0] res_c, s2_res, s3_res;
   logic [2:0]  flg_c, s2_flg, s3_flg;
   assign stall        = vld[2] & !bus.out_ready;
   assign bus.in_ready = !stall | !rst_n;
   assign bus.out_valid = vld[2];
   assign bus.result_o  = s3_res;
   assign {bus.inexact_o, bus.overflow_o, bus.underflow_o} = s3_flg;
   always_comb begin
      inx    = s1_g | s1_r | s1_s;
      up     = s1_mode == RNE ? s1_g & (s1_r | s1_s | s1_mant[0]) :
               s1_mode == RTZ ? 1'b0 :
               s1_mode == RUP ? !s1_sign & inx : s1_sign & inx;
      mant_r = {1'b0, s1_mant} + 54'(up);
      exp_r  = mant_r[53] ? {1'b0, s1_exp} + 12'd1 :
               (s1_exp == 11'd0 && mant_r[52]) ? 12'd1 : {1'b0, s1_exp};
      frac_r = mant_r[53] ? mant_r[52:1] : mant_r[51:0];
      ovf    = exp_r >= 12'd2047;
      to_inf = s1_mode == RNE | (s1_mode == RUP & !s1_sign) | (s1_mode == RDN & s1_sign);
      zero   = s1_mant == 53'd0 && s1_exp == 11'd0 && !inx;
      // exact zero takes its sign from the rounding mode, not from the datapath
      res_c  = zero ? {s1_mode == RDN, 63'd0} :
               ovf ? (to_inf ? {s1_sign, 11'h7ff, 52'd0} : {s1_sign, 11'h7fe, {52{1'b1}}}) :
               {s1_sign, exp_r[10:0], frac_r};
      flg_c  = {inx | ovf, ovf, !ovf && exp_r == 12'd0 && inx};
   end
   always_ff @(posedge clk) begin
      if (!stall) begin
         s1_sign <= bus.sign_i;
         s1_mant <= bus.diff_i[54:2];
         s1_g    <= bus.diff_i[1];
         s1_r    <= bus.diff_i[0];
         s1_s    <= bus.sticky_i;
         s1_exp  <= bus.exponent_i;
         s1_mode <= mode_e'(bus.round_mode);
         s2_res  <= res_c;
         s2_flg  <= flg_c;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld    <= 3'd0;
         s3_res <= 64'd0;
         s3_flg <= 3'd0;
      end else begin
         if (!stall) begin
            vld    <= {vld[1:0], bus.in_valid};
            s3_res <= s2_res;
            s3_flg <= s2_flg;
         end
         if (bus.flush) vld <= 3'd0;
      end
   end
endmodule

// File: tb/tb_fpu_sub_round.sv
// tb_fpu_sub_round: directed vectors with hand-computed results for the
// round/pack stage, plus backpressure, reset and flush sequences.
module tb_fpu_sub_round;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   localparam logic [51:0] ALL = {52{1'b1}};
   fpu_sub_round_if bus ();
   fpu_sub_round dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [55:0] mkdiff(input logic hid, input logic [51:0] fr, input logic g, input logic r);
      return {1'b0, hid, fr, g, r};
   endfunction
   task automatic drive(input logic sg, input logic [55:0] d, input logic [10:0] e, input logic st, input logic [1:0] m);
      bus.sign_i     = sg;
      bus.diff_i     = d;
      bus.exponent_i = e;
      bus.sticky_i   = st;
      bus.round_mode = m;
   endtask
   task automatic run_one(input string tag, input logic sg, input logic [55:0] d, input logic [10:0] e,
                          input logic st, input logic [1:0] m, input logic [63:0] er, input logic [2:0] ef);
      drive(sg, d, e, st, m);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      check({tag, "_early"}, 64'(bus.out_valid), 64'd0);
      step();
      check({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
      check(tag, bus.result_o, er);
      check({tag, "_flg"}, 64'({bus.inexact_o, bus.overflow_o, bus.underflow_o}), 64'(ef));
      step();
   endtask
   function automatic logic [63:0] bp_res(input int i);
      return {1'b0, 11'(11'h400 + i), 52'(i)};
   endfunction
   initial begin
      int first, n_sent, n_got;
      logic fire_in, fire_out;
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b0, 56'd0, 11'd0, 1'b0, 2'd0);
      step();
      step();
      check("rst_vld", 64'(bus.out_valid), 64'd0);
      check("rst_res", bus.result_o, 64'd0);
      check("rst_flg", 64'({bus.inexact_o, bus.overflow_o, bus.underflow_o}), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      rst_n = 1'b1;
      step();
      run_one("rne_tie_even", 1'b0, mkdiff(1'b1, 52'd0, 1'b1, 1'b0), 11'h3ff, 1'b0, 2'd0, 64'h3FF0000000000000, 3'b100);
      run_one("rne_tie_odd",  1'b0, mkdiff(1'b1, 52'd1, 1'b1, 1'b0), 11'h3ff, 1'b0, 2'd0, 64'h3FF0000000000002, 3'b100);
      run_one("carry",        1'b0, mkdiff(1'b1, ALL, 1'b1, 1'b0),   11'h3ff, 1'b0, 2'd0, 64'h4000000000000000, 3'b100);
      run_one("ovf_rup",      1'b0, mkdiff(1'b1, ALL, 1'b1, 1'b0),   11'h7fe, 1'b0, 2'd2, 64'h7FF0000000000000, 3'b110);
      run_one("ovf_rtz",      1'b0, mkdiff(1'b1, ALL, 1'b1, 1'b0),   11'h7fe, 1'b0, 2'd1, 64'h7FEFFFFFFFFFFFFF, 3'b100);
      run_one("ovf_rdn",      1'b1, mkdiff(1'b1, ALL, 1'b1, 1'b0),   11'h7fe, 1'b0, 2'd3, 64'hFFF0000000000000, 3'b110);
      run_one("ovf_rne_neg",  1'b1, mkdiff(1'b1, ALL, 1'b1, 1'b0),   11'h7fe, 1'b0, 2'd0, 64'hFFF0000000000000, 3'b110);
      run_one("ovf_rup_neg",  1'b1, mkdiff(1'b1, 52'd0, 1'b0, 1'b0), 11'h7ff, 1'b0, 2'd2, 64'hFFEFFFFFFFFFFFFF, 3'b110);
      run_one("zero_rdn",     1'b0, 56'd0, 11'd0, 1'b0, 2'd3, 64'h8000000000000000, 3'b000);
      run_one("zero_rne",     1'b1, 56'd0, 11'd0, 1'b0, 2'd0, 64'h0000000000000000, 3'b000);
      run_one("underflow",    1'b0, mkdiff(1'b0, 52'd1, 1'b0, 1'b1), 11'd0,   1'b0, 2'd0, 64'h0000000000000001, 3'b101);
      run_one("denorm_norm",  1'b0, mkdiff(1'b0, ALL, 1'b1, 1'b0),   11'd0,   1'b0, 2'd0, 64'h0010000000000000, 3'b100);
      run_one("rdn_sticky",   1'b1, mkdiff(1'b1, 52'd0, 1'b0, 1'b0), 11'h3ff, 1'b1, 2'd3, 64'hBFF0000000000001, 3'b100);
      run_one("rup_neg",      1'b1, mkdiff(1'b1, 52'd0, 1'b0, 1'b0), 11'h3ff, 1'b1, 2'd2, 64'hBFF0000000000000, 3'b100);
      // five back-to-back beats, consumer holds off for six cycles from the first result
      first = -1;
      n_sent = 0;
      n_got = 0;
      for (int cyc = 0; cyc < 60 && n_got < 5; cyc++) begin
         if (bus.out_valid && first < 0) first = cyc;
         bus.out_ready = !(first >= 0 && cyc < first + 6);
         bus.in_valid  = n_sent < 5;
         drive(1'b0, mkdiff(1'b1, 52'(n_sent), 1'b0, 1'b0), 11'(11'h400 + n_sent), 1'b0, 2'd1);
         #1;
         if (first >= 0 && cyc == first) check("bp_in_ready_drop", 64'(bus.in_ready), 64'd0);
         if (first >= 0 && cyc == first + 5) check("bp_hold", bus.result_o, bp_res(0));
         fire_in  = bus.in_valid & bus.in_ready;
         fire_out = bus.out_valid & bus.out_ready;
         if (fire_out) begin
            check($sformatf("bp_res%0d", n_got), bus.result_o, bp_res(n_got));
            n_got++;
         end
         if (fire_in) n_sent++;
         step();
      end
      check("bp_count", 64'(n_got), 64'd5);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      step();
      check("bp_no_dup", 64'(bus.out_valid), 64'd0);
      // reset with three beats in flight and the output stalled
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, mkdiff(1'b1, 52'd7, 1'b0, 1'b0), 11'h3ff, 1'b0, 2'd0);
         bus.in_valid = 1'b1;
         step();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
      step();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      check("mid_rst_vld", 64'(bus.out_valid), 64'd0);
      check("mid_rst_res", bus.result_o, 64'd0);
      for (int i = 0; i < 4; i++) begin
         if (bus.out_valid) check("mid_rst_stale", 64'(bus.out_valid), 64'd0);
         step();
      end
      run_one("post_rst", 1'b0, mkdiff(1'b1, 52'd5, 1'b0, 1'b0), 11'h401, 1'b0, 2'd0, 64'h4010000000000005, 3'b000);
      // flush with three beats in flight; the beat offered on the flush edge is dropped
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, mkdiff(1'b1, 52'd9, 1'b0, 1'b0), 11'h3ff, 1'b0, 2'd0);
         bus.in_valid = 1'b1;
         step();
      end
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_vld", 64'(bus.out_valid), 64'd0);
      for (int i = 0; i < 4; i++) begin
         if (bus.out_valid) check("flush_stale", 64'(bus.out_valid), 64'd0);
         step();
      end
      run_one("post_flush", 1'b1, mkdiff(1'b1, 52'd3, 1'b0, 1'b0), 11'h3fe, 1'b0, 2'd0, 64'hBFE0000000000003, 3'b000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
